// File: rtl/bp_cfg_link_pkg.sv
// Shared config-link definitions for the boot sequencer: processor config
// table, config-link register addresses and the sequencer state encoding.
package bp_cfg_link_pkg;

    // Processor configurations selectable through cfg_p
    typedef enum logic [1:0] {
        e_bp_single_core_cfg = 2'd0,
        e_bp_quad_core_cfg   = 2'd1
    } bp_cfg_e;

    // Subset of processor parameters the sequencer is sized from
    typedef struct packed {
        logic [31:0] num_core;
        logic [31:0] num_cce_instr_ram_els;
    } bp_proc_param_s;

    localparam bp_proc_param_s all_cfgs_gp [2] = '{
        '{num_core: 32'd1, num_cce_instr_ram_els: 32'd256},
        '{num_core: 32'd4, num_cce_instr_ram_els: 32'd256}
    };

    // Config-link register map
    localparam logic [15:0] cfg_addr_freeze_gp     = 16'h0001;
    localparam logic [15:0] cfg_addr_core_id_gp    = 16'h0002;
    localparam logic [15:0] cfg_addr_icache_id_gp  = 16'h0003;
    localparam logic [15:0] cfg_addr_dcache_id_gp  = 16'h0004;
    localparam logic [15:0] cfg_addr_cce_mode_gp   = 16'h0005;
    localparam logic [15:0] cfg_addr_ucode_base_gp = 16'h8000;

    // Sequencer states
    typedef enum logic [3:0] {
        e_cfg_reset    = 4'd0,
        e_cfg_idle     = 4'd1,
        e_cfg_freeze   = 4'd2,
        e_cfg_core_id  = 4'd3,
        e_cfg_icache   = 4'd4,
        e_cfg_dcache   = 4'd5,
        e_cfg_ucode_rd = 4'd6,
        e_cfg_ucode_wr = 4'd7,
        e_cfg_mode     = 4'd8,
        e_cfg_unfreeze = 4'd9,
        e_cfg_done     = 4'd10
    } bp_cfg_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear.
// Ports: clk_i, reset_i (sync, active-high), clear_i, up_i, count_o.
module bsg_counter_clear_up #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    // Clear has priority over increment
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count_o <= '0;
        end else if (up_i) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bp_cfg_sequencer.sv
// Boot-time config sequencer: freezes all cores, writes per-core core/LCE ids,
// streams CCE microcode from a synchronous ROM into CCE 0, sets the CCE mode
// and unfreezes.
// Ports: clk_i/reset_i (sync active-high), start_i, cfg_* write channel with
// cfg_ready_i handshake, rom_addr_o/rom_data_i microcode ROM, busy_o, done_o.
module bp_cfg_sequencer
    import bp_cfg_link_pkg::*;
#(
    parameter bp_cfg_e     cfg_p             = e_bp_single_core_cfg,
    parameter int unsigned cce_instr_width_p = 48,
    parameter int unsigned cfg_addr_width_p  = 16,
    parameter int unsigned cfg_data_width_p  = 64,
    parameter int unsigned cce_mode_p        = 0,
    localparam bp_proc_param_s proc_param_lp = all_cfgs_gp[cfg_p],
    localparam int unsigned num_core_lp      = proc_param_lp.num_core,
    localparam int unsigned num_els_lp       = proc_param_lp.num_cce_instr_ram_els,
    localparam int unsigned core_width_lp    = (num_core_lp > 1) ? $clog2(num_core_lp) : 1,
    localparam int unsigned rom_width_lp     = (num_els_lp > 1) ? $clog2(num_els_lp) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    output logic                         cfg_v_o,
    input  logic                         cfg_ready_i,
    output logic                         cfg_bcast_o,
    output logic [core_width_lp-1:0]     cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    output logic [rom_width_lp-1:0]      rom_addr_o,
    input  logic [cce_instr_width_p-1:0] rom_data_i,
    output logic                         busy_o,
    output logic                         done_o
);

    bp_cfg_state_e             state_r, state_n;
    logic [core_width_lp-1:0]  core_r;
    logic [rom_width_lp-1:0]   ucode_idx;
    logic                      fire;
    logic                      last_core;
    logic                      last_word;
    logic                      idx_up;
    logic                      idx_clear;

    // cfg_v_o decodes from state only, so this has no loop back to outputs
    assign fire      = cfg_v_o & cfg_ready_i;
    assign last_core = (core_r == core_width_lp'(num_core_lp - 1));
    assign last_word = (ucode_idx == rom_width_lp'(num_els_lp - 1));
    assign idx_up    = (state_r == e_cfg_ucode_wr) && fire && !last_word;
    assign idx_clear = (state_r == e_cfg_ucode_wr) && fire && last_word;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_cfg_reset;
        end else begin
            state_r <= state_n;
        end
    end

    // Core counter; wraps to 0 after the last core's DCACHE write
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            core_r <= '0;
        end else if ((state_r == e_cfg_dcache) && fire) begin
            core_r <= last_core ? '0 : core_r + core_width_lp'(1);
        end
    end

    // Microcode index; held through UCODE_WR so the ROM data stays valid
    bsg_counter_clear_up #(
        .width_p (rom_width_lp)
    ) u_ucode_idx (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (idx_clear),
        .up_i    (idx_up),
        .count_o (ucode_idx)
    );

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_cfg_reset:    state_n = e_cfg_idle;
            e_cfg_idle,
            e_cfg_done:     if (start_i) state_n = e_cfg_freeze;
            e_cfg_freeze:   if (fire) state_n = e_cfg_core_id;
            e_cfg_core_id:  if (fire) state_n = e_cfg_icache;
            e_cfg_icache:   if (fire) state_n = e_cfg_dcache;
            e_cfg_dcache:   if (fire) state_n = last_core ? e_cfg_ucode_rd : e_cfg_core_id;
            e_cfg_ucode_rd: state_n = e_cfg_ucode_wr;
            e_cfg_ucode_wr: if (fire) state_n = last_word ? e_cfg_mode : e_cfg_ucode_rd;
            e_cfg_mode:     if (fire) state_n = e_cfg_unfreeze;
            e_cfg_unfreeze: if (fire) state_n = e_cfg_done;
            default:        state_n = e_cfg_reset;
        endcase
    end

    // Output decode from registered state, core counter and index
    always_comb begin
        cfg_v_o     = 1'b0;
        cfg_bcast_o = 1'b0;
        cfg_core_o  = '0;
        cfg_addr_o  = '0;
        cfg_data_o  = '0;
        rom_addr_o  = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_r)
            e_cfg_freeze: begin
                busy_o      = 1'b1;
                cfg_v_o     = 1'b1;
                cfg_bcast_o = 1'b1;
                cfg_addr_o  = cfg_addr_width_p'(cfg_addr_freeze_gp);
                cfg_data_o  = cfg_data_width_p'(1);
            end
            e_cfg_core_id: begin
                busy_o     = 1'b1;
                cfg_v_o    = 1'b1;
                cfg_core_o = core_r;
                cfg_addr_o = cfg_addr_width_p'(cfg_addr_core_id_gp);
                cfg_data_o = cfg_data_width_p'(core_r);
            end
            e_cfg_icache: begin
                busy_o     = 1'b1;
                cfg_v_o    = 1'b1;
                cfg_core_o = core_r;
                cfg_addr_o = cfg_addr_width_p'(cfg_addr_icache_id_gp);
                cfg_data_o = cfg_data_width_p'({core_r, 1'b0});
            end
            e_cfg_dcache: begin
                busy_o     = 1'b1;
                cfg_v_o    = 1'b1;
                cfg_core_o = core_r;
                cfg_addr_o = cfg_addr_width_p'(cfg_addr_dcache_id_gp);
                cfg_data_o = cfg_data_width_p'({core_r, 1'b1});
            end
            e_cfg_ucode_rd: begin
                busy_o     = 1'b1;
                rom_addr_o = ucode_idx;
            end
            e_cfg_ucode_wr: begin
                busy_o     = 1'b1;
                cfg_v_o    = 1'b1;
                rom_addr_o = ucode_idx;
                cfg_addr_o = cfg_addr_width_p'(cfg_addr_ucode_base_gp)
                           + cfg_addr_width_p'(ucode_idx);
                cfg_data_o = cfg_data_width_p'(rom_data_i);
            end
            e_cfg_mode: begin
                busy_o     = 1'b1;
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width_p'(cfg_addr_cce_mode_gp);
                cfg_data_o = cfg_data_width_p'(cce_mode_p);
            end
            e_cfg_unfreeze: begin
                busy_o      = 1'b1;
                cfg_v_o     = 1'b1;
                cfg_bcast_o = 1'b1;
                cfg_addr_o  = cfg_addr_width_p'(cfg_addr_freeze_gp);
            end
            e_cfg_done: done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Directed bench for bp_cfg_sequencer: single-core and quad-core instances,
// write-trace capture, reference write list built from the register map.
module tb_bp_cfg_sequencer;
    import bp_cfg_link_pkg::*;

    typedef struct packed {
        logic        bcast;
        logic [1:0]  core;
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    localparam int unsigned NUM_ELS = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    logic        start   = 1'b0;
    logic        start_q = 1'b0;
    logic        ready   = 1'b1;

    // single-core instance
    logic        v, bcast, busy, done;
    logic [0:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  rom_addr;
    logic [47:0] rom_data;

    // quad-core instance
    logic        v_q, bcast_q, busy_q, done_q;
    logic [1:0]  core_q;
    logic [15:0] addr_q;
    logic [63:0] data_q;
    logic [7:0]  rom_addr_q;
    logic [47:0] rom_data_q;

    int checks = 0;
    int errors = 0;
    wr_t trace[$];
    wr_t trace_q[$];

    bp_cfg_sequencer #(.cfg_p(e_bp_single_core_cfg)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start),
        .cfg_v_o(v), .cfg_ready_i(ready), .cfg_bcast_o(bcast),
        .cfg_core_o(core), .cfg_addr_o(addr), .cfg_data_o(data),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .busy_o(busy), .done_o(done)
    );

    bp_cfg_sequencer #(.cfg_p(e_bp_quad_core_cfg)) dut_q (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_q),
        .cfg_v_o(v_q), .cfg_ready_i(1'b1), .cfg_bcast_o(bcast_q),
        .cfg_core_o(core_q), .cfg_addr_o(addr_q), .cfg_data_o(data_q),
        .rom_addr_o(rom_addr_q), .rom_data_i(rom_data_q),
        .busy_o(busy_q), .done_o(done_q)
    );

    // Synchronous ROMs holding word i at address i
    always @(posedge clk) rom_data   <= 48'(rom_addr);
    always @(posedge clk) rom_data_q <= 48'(rom_addr_q);

    // Capture accepted writes; core is don't-care on broadcasts
    always @(posedge clk) begin
        if (!reset_i && v && ready)
            trace.push_back(wr_t'({bcast, bcast ? 2'b00 : 2'(core), addr, data}));
        if (!reset_i && v_q)
            trace_q.push_back(wr_t'({bcast_q, bcast_q ? 2'b00 : core_q, addr_q, data_q}));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: i-th write of a full sequence for ncore cores
    function automatic wr_t exp_wr(input int ncore, input int i);
        wr_t w;
        int  k;
        w = '0;
        if (i == 0) begin
            w.bcast = 1'b1; w.addr = 16'h0001; w.data = 64'd1;
        end else if (i < 1 + 3 * ncore) begin
            k = i - 1;
            w.core = 2'(k / 3);
            case (k % 3)
                0:       begin w.addr = 16'h0002; w.data = 64'(k / 3); end
                1:       begin w.addr = 16'h0003; w.data = 64'(2 * (k / 3)); end
                default: begin w.addr = 16'h0004; w.data = 64'(2 * (k / 3) + 1); end
            endcase
        end else if (i < 1 + 3 * ncore + NUM_ELS) begin
            k = i - 1 - 3 * ncore;
            w.addr = 16'h8000 + 16'(k);
            w.data = 64'(k);
        end else if (i == 1 + 3 * ncore + NUM_ELS) begin
            w.addr = 16'h0005; w.data = 64'd0;
        end else begin
            w.bcast = 1'b1; w.addr = 16'h0001; w.data = 64'd0;
        end
        return w;
    endfunction

    task automatic check_trace(input string tag, input bit quad, input int len);
        int ncore;
        int sz;
        ncore = quad ? 4 : 1;
        sz = quad ? trace_q.size() : trace.size();
        chk({tag, "_len"}, 128'(sz), 128'(len));
        for (int i = 0; i < len && i < sz; i++)
            chk($sformatf("%s_wr%0d", tag, i), quad ? 128'(trace_q[i]) : 128'(trace[i]),
                128'(exp_wr(ncore, i)));
    endtask

    initial begin
        int n;
        int stalls;
        bit prev_stall;
        logic [127:0] prev_out;

        // reset values
        tick(); tick();
        chk("reset_outputs", {v, bcast, core, addr, data, rom_addr, busy, done}, '0);
        reset_i = 1'b0;
        tick();
        chk("idle_outputs", {v, bcast, core, addr, data, rom_addr, busy, done}, '0);

        // full run, ready tied high, both configs
        trace.delete(); trace_q.delete();
        start = 1'b1; start_q = 1'b1;
        tick();
        start = 1'b0; start_q = 1'b0;
        chk("freeze_after_start", {busy, v, bcast, addr, data}, {1'b1, 1'b1, 1'b1, 16'h0001, 64'd1});
        n = 1;
        while (!done && n < 3000) begin tick(); n++; end
        chk("done_latency_1core", 128'(n), 128'(519));
        chk("done_outputs", {v, busy, done}, 3'b001);
        while (!done_q && n < 3000) begin tick(); n++; end
        chk("done_latency_4core", 128'(n), 128'(528));
        check_trace("run1", 1'b0, 262);
        check_trace("quad", 1'b1, 271);

        // rerun from DONE with 50% random ready
        trace.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rerun_done_drop", {done, busy, v, addr}, {1'b0, 1'b1, 1'b1, 16'h0001});
        n = 1; stalls = 0; prev_stall = 1'b0; prev_out = '0;
        while (!done && n < 3000) begin
            if (prev_stall)
                chk("stall_hold", {v, bcast, core, addr, data, rom_addr},
                    prev_out);
            prev_out = 128'({v, bcast, core, addr, data, rom_addr});
            ready = 1'($urandom_range(0, 1));
            prev_stall = v && !ready;
            if (prev_stall) stalls++;
            tick();
            n++;
        end
        ready = 1'b1;
        chk("stretch_cycles", 128'(n), 128'(519 + stalls));
        check_trace("stall", 1'b0, 262);

        // start during UCODE_RD is ignored; reset during UCODE_WR index 100
        trace.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(rom_addr == 8'd5 && !v) && n < 2000) begin tick(); n++; end
        chk("reach_ucode_rd5", {rom_addr, v, busy}, {8'd5, 1'b0, 1'b1});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", {busy, v, addr, rom_addr, data}, {1'b1, 1'b1, 16'h8005, 8'd5, 64'd5});
        n = 0;
        while (!(v && addr == 16'h8064) && n < 2000) begin tick(); n++; end
        chk("reach_ucode_wr100", {v, addr, data, rom_addr}, {1'b1, 16'h8064, 64'd100, 8'd100});
        reset_i = 1'b1;
        tick();
        chk("mid_reset_outputs", {v, bcast, core, addr, data, rom_addr, busy, done}, '0);
        reset_i = 1'b0;
        check_trace("partial", 1'b0, 104);
        tick();
        chk("post_reset_idle", {v, rom_addr, busy, done}, '0);
        tick();
        chk("no_auto_restart", {v, busy, done}, '0);

        // new start replays from FREEZE with index 0
        trace.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("replay_freeze", {busy, v, bcast, addr}, {1'b1, 1'b1, 1'b1, 16'h0001});
        n = 1;
        while (!done && n < 3000) begin tick(); n++; end
        chk("replay_latency", 128'(n), 128'(519));
        check_trace("replay", 1'b0, 262);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
